pipelined_cla_adder: RTL and testbench
======================================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. Splits a WIDTH-bit operation into GROUP-bit lookahead groups, with one register stage per group, so every pipeline stage has a bounded critical path. Valid/ready handshakes sit on both sides. It serves as the arithmetic core for wide datapaths that need one result per cycle at high clock rates.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of GROUP
GROUP, 4, bits per lookahead group; legal range 1..8; illegal WIDTH/GROUP combination is an elaboration error
NUM_GROUPS, WIDTH/GROUP, derived (localparam): number of pipeline stages and the latency in cycles

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
carry_in  input  1  carry into bit 0 for add mode; ignored when sub=1
sub  input  1  0: a+b+carry_in; 1: a-b (a + ~b + 1)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result this cycle
sum  output  WIDTH  result
carry_out  output  1  carry out of MSB (sub: 1 = no borrow)
overflow  output  1  signed overflow, carry into MSB XOR carry out of MSB

Behaviour:
- Reset (sampled on clk edge with reset=1):
  - All stage valid bits = 0.
  - out_valid=0, sum=0, carry_out=0, overflow=0.
  - Reset has priority over every other event and discards all in-flight beats. in_ready=1 in the first cycle after reset.
- Effective operands:
  - b_eff = sub ? ~b : b.
  - cin_eff = sub ? 1 : carry_in.
  - Both are captured with the beat; later changes on the input ports do not affect in-flight beats.
- Group logic, per bit:
  - g = a & b_eff, p = a ^ b_eff.
  - Lookahead carries inside a group are flattened: c[i+1] = g[i] | p[i]&g[i-1] | ... | p[i]..p[0]&cin. No ripple inside a group.
  - Sum bit = p ^ c.
- Pipeline:
  - Stage k (k=0..NUM_GROUPS-1) resolves group k from the registered group carry of stage k-1.
  - Stage 0 uses cin_eff.
  - Not-yet-processed operand slices travel with the beat; finished sum slices accumulate.
- Advance and handshake:
  - advance = !out_valid || out_ready. On advance, every stage shifts by one; valid bits shift too, so bubbles propagate.
  - in_ready = advance, combinational from out_valid/out_ready only, never from in_valid.
  - A beat is accepted when in_valid && in_ready.
  - When advance=0, all stages hold and inputs are ignored.
- Latency and throughput:
  - Accept on edge N gives out_valid=1 after edge N+NUM_GROUPS-1. For WIDTH=16, GROUP=4 that is 4 cycles from accept to result visible.
  - Throughput is one beat per cycle when out_ready=1.
- Output register:
  - sum, carry_out and overflow are registered and hold stable while out_valid && !out_ready.
  - Data is unchanged when out_valid=0 and no new beat arrives.
- Ordering: results leave in acceptance order, with no loss or duplication under arbitrary in_valid/out_ready patterns.
- Simultaneous events: accepting a new beat and retiring the output in the same cycle is legal and is the steady-state case.
- Wrap-around: arithmetic is modulo 2^WIDTH; carry_out and overflow report the wrap.

Optional Feature:
Macro: CLA_SAT_EN
- Defined:
  - When overflow=1, sum saturates to the sign of a: a[WIDTH-1]=0 gives 0111..1, a[WIDTH-1]=1 gives 1000..0.
  - overflow and carry_out are still reported unmodified.
  - Saturation is applied in the final stage, so latency is unchanged.
- Not defined: sum is the raw modulo result; no extra logic.

Test Plan:
1. Reset with out_ready=1, in_valid=0 -> out_valid=0, sum=0x0000, in_ready=1; repeat with reset asserted mid-stream (3 beats in flight) -> out_valid=0 after the reset edge, no stale beat ever appears.
2. a=0x00FF, b=0x0001, carry_in=0, sub=0 (WIDTH=16) -> after 4 cycles sum=0x0100, carry_out=0, overflow=0.
3. Full-width carry propagation: a=0xFFFF, b=0x0000, carry_in=1 -> sum=0x0000, carry_out=1, overflow=0.
4. Subtract: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, carry_out=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry_out=1, overflow=1.
5. Stream 32 random beats back-to-back while out_ready follows a random pattern (≥30% low) -> results match the golden model in order; in_ready equals !out_valid||out_ready every cycle; outputs stable while stalled.
6. a=0x7FFF, b=0x0001, sub=0 -> overflow=1; sum=0x7FFF with CLA_SAT_EN defined, sum=0x8000 without.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined carry-lookahead adder/subtractor. The WIDTH-bit operation is cut
//   into GROUP-bit lookahead groups; group k is resolved in pipeline stage k
//   from the registered carry of stage k-1. Latency is NUM_GROUPS cycles, and
//   throughput is one beat per cycle while the output is drained.
//
//   Optional build macro: CLA_SAT_EN -- saturate sum on signed overflow
//   (toward the sign of a). carry_out/overflow are reported unmodified.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset, drops all in-flight beats
//   in_valid_i   operand beat valid
//   in_ready_o   beat accepted this cycle if in_valid_i (= !out_valid_o || out_ready_i)
//   a_i, b_i     operands
//   carry_in_i   carry into bit 0 in add mode, ignored when sub_i=1
//   sub_i        0: a+b+carry_in, 1: a-b
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   sum_o        result (modulo 2^WIDTH, or saturated with CLA_SAT_EN)
//   carry_out_o  carry out of MSB (subtract: 1 = no borrow)
//   overflow_o   signed overflow
module pipelined_cla_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned GROUP = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_in_i,
   input  logic             sub_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_out_o,
   output logic             overflow_o
);

   localparam int unsigned NUM_GROUPS = WIDTH / GROUP;

   if (GROUP < 1 || GROUP > 8 || (WIDTH % GROUP) != 0) begin : g_param_err
      $error("pipelined_cla_adder: illegal WIDTH/GROUP combination");
   end

   logic             advance;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Whole pipeline moves as one shift register; never depends on in_valid_i.
   assign advance    = !out_valid_o || out_ready_i;
   assign in_ready_o = advance;
   assign b_eff      = sub_i ? ~b_i : b_i;
   assign cin_eff    = sub_i | carry_in_i;

   for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_stage
      localparam int unsigned Lo  = k * GROUP;
      localparam int unsigned Hi  = Lo + GROUP;
      localparam int unsigned OpW = WIDTH - Lo;

      // op_a/op_b: operand slices not yet processed, group k in the low bits
      logic [OpW-1:0]   op_a;
      logic [OpW-1:0]   op_b;
      logic             v_in;
      logic             c_in;
      logic [GROUP-1:0] g;
      logic [GROUP-1:0] p;
      logic [GROUP-1:0] s;
      logic [GROUP:0]   c;
      logic [Hi-1:0]    s_acc;
      logic [Hi-1:0]    s_d;
      logic [Hi-1:0]    s_q;
      logic             v_q;
      logic             c_q;

      if (k == 0) begin : g_src
         assign op_a  = a_i;
         assign op_b  = b_eff;
         assign v_in  = in_valid_i;
         assign c_in  = cin_eff;
         assign s_acc = s;
      end else begin : g_src
         assign op_a  = g_stage[k-1].g_fwd.a_q;
         assign op_b  = g_stage[k-1].g_fwd.b_q;
         assign v_in  = g_stage[k-1].v_q;
         assign c_in  = g_stage[k-1].c_q;
         assign s_acc = {s, g_stage[k-1].s_q};
      end

      assign g = op_a[GROUP-1:0] & op_b[GROUP-1:0];
      assign p = op_a[GROUP-1:0] ^ op_b[GROUP-1:0];

      // Flattened sum-of-products lookahead: every carry is a two-level
      // function of g, p and c_in, no carry feeds another.
      always_comb begin
         logic term;
         logic acc;
         term = 1'b0;
         acc  = 1'b0;
         c    = '0;
         c[0] = c_in;
         for (int i = 0; i < int'(GROUP); i++) begin
            acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
               term = g[j];
               for (int m = j + 1; m <= i; m++) term = term & p[m];
               acc = acc | term;
            end
            term = c_in;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = acc | term;
         end
      end

      assign s = p ^ c[GROUP-1:0];

      if (k == NUM_GROUPS - 1) begin : g_last
         logic ovf;
         logic ovf_q;

         assign ovf = c[GROUP] ^ c[GROUP-1];

`ifdef CLA_SAT_EN
         // a and b_eff share a sign whenever ovf is set, so a's MSB picks the rail.
         always_comb begin
            s_d = s_acc;
            if (ovf) begin
               s_d = op_a[GROUP-1] ? {1'b1, {(Hi-1){1'b0}}} : {1'b0, {(Hi-1){1'b1}}};
            end
         end
`else
         assign s_d = s_acc;
`endif

         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               ovf_q <= 1'b0;
            end else if (advance && v_in) begin
               ovf_q <= ovf;
            end
         end
      end else begin : g_fwd
         logic [OpW-GROUP-1:0] a_q;
         logic [OpW-GROUP-1:0] b_q;

         assign s_d = s_acc;

         always_ff @(posedge clk_i) begin
            if (reset_i) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance && v_in) begin
               a_q <= op_a[OpW-1:GROUP];
               b_q <= op_b[OpW-1:GROUP];
            end
         end
      end

      // Data only loads with a real beat so bubbles leave outputs untouched.
      always_ff @(posedge clk_i) begin
         if (reset_i) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
         end else if (advance) begin
            v_q <= v_in;
            if (v_in) begin
               c_q <= c[GROUP];
               s_q <= s_d;
            end
         end
      end
   end

   assign out_valid_o = g_stage[NUM_GROUPS-1].v_q;
   assign sum_o       = g_stage[NUM_GROUPS-1].s_q;
   assign carry_out_o = g_stage[NUM_GROUPS-1].c_q;
   assign overflow_o  = g_stage[NUM_GROUPS-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder
//   Self-checking bench for pipelined_cla_adder (WIDTH=16, GROUP=4): reset,
//   mid-stream reset, directed add/subtract vectors with latency, and a
//   back-pressured stream checked in order against a reference model.
//   Honours CLA_SAT_EN the same way the design does.
module tb_pipelined_cla_adder;

   localparam int unsigned W   = 16;
   localparam int unsigned LAT = 4;

`ifdef CLA_SAT_EN
   localparam logic [15:0] ExpV4 = 16'h8000;
   localparam logic [15:0] ExpV5 = 16'h7FFF;
   localparam logic [15:0] ExpV8 = 16'h8000;
`else
   localparam logic [15:0] ExpV4 = 16'h7FFF;
   localparam logic [15:0] ExpV5 = 16'h8000;
   localparam logic [15:0] ExpV8 = 16'h0000;
`endif

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;

   int n_checks = 0;
   int n_pass   = 0;

   pipelined_cla_adder #(
      .WIDTH (16),
      .GROUP (4)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .a_i         (a),
      .b_i         (b),
      .carry_in_i  (carry_in),
      .sub_i       (sub),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .sum_o       (sum),
      .carry_out_o (carry_out),
      .overflow_o  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Reference: {overflow, carry_out, sum}
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mcin, input logic msub);
      logic [15:0] be;
      logic [16:0] r;
      logic [15:0] s;
      logic        ov;
      be = msub ? ~mb : mb;
      r  = {1'b0, ma} + {1'b0, be} + {16'b0, (msub | mcin)};
      ov = (ma[15] == be[15]) && (r[15] != ma[15]);
      s  = r[15:0];
`ifdef CLA_SAT_EN
      if (ov) s = ma[15] ? 16'h8000 : 16'h7FFF;
`endif
      return {ov, r[16], s};
   endfunction

   task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                          input logic vcin, input logic vsub, input logic [15:0] es,
                          input logic eco, input logic eov);
      int n;
      @(negedge clk);
      a = va; b = vb; carry_in = vcin; sub = vsub; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      #1;
      // Scramble ports: the in-flight beat must not see these.
      in_valid = 1'b0; a = ~va; b = vb ^ 16'h5A5A; carry_in = ~vcin; sub = ~vsub;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!out_valid && n < 20);
      check({tag, "_lat"}, n, LAT);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, carry_out, eco);
      check({tag, "_ovf"}, overflow, eov);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] q[$];
      int          sent;
      int          cycles;
      int          stale;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", carry_out, 0);
      check("rst_ovf", overflow, 0);
      check("rst_in_ready", in_ready, 1);
      reset = 1'b0;

      // Reset with three beats in flight
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_valid = 1'b1; a = 16'(16'h1111 * (i + 1)); b = 16'h0101;
      end
      @(negedge clk);
      in_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      check("midrst_in_ready", in_ready, 1);
      reset = 1'b0;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("midrst_no_stale", stale, 0);

      // Directed vectors
      run_one("v1_add",      16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
      run_one("v2_fullprop", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("v3_sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_one("v4_sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, ExpV4,    1'b1, 1'b1);
      run_one("v5_add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, ExpV5,    1'b0, 1'b1);
      run_one("v6_sub_zero", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_one("v7_sub_cin",  16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
      run_one("v8_negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, ExpV8,    1'b1, 1'b1);
      run_one("v9_cin_prop", 16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_one("v10_plain",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

      repeat (2) @(negedge clk);

      // Back-to-back stream under random back-pressure
      sent = 0;
      cycles = 0;
      while ((sent < 32 || q.size() != 0) && cycles < 600) begin
         @(negedge clk);
         cycles++;
         if (out_valid) begin
            if (q.size() == 0) check("stream_spurious", 1, 0);
            else check("stream_data", {14'b0, overflow, carry_out, sum}, {14'b0, q[0]});
         end
         out_ready = ($urandom_range(0, 9) >= 4);
         if (sent < 32) begin
            in_valid = 1'b1;
            a = 16'($urandom); b = 16'($urandom);
            carry_in = 1'($urandom); sub = 1'($urandom);
         end else begin
            in_valid = 1'b0;
         end
         #1;
         check("stream_in_ready", in_ready, !out_valid || out_ready);
         if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
         if (in_valid && in_ready) begin
            q.push_back(model(a, b, carry_in, sub));
            sent++;
         end
      end
      check("stream_drained", q.size() + (32 - sent), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
